store_ctrl_ram: RTL

Store-path counterpart of the RAM load output controller. It takes CPU store requests (byte, halfword or word) and drives a word-wide, word-addressed data RAM that has no byte enables. Word stores complete in a single write. Sub-word stores run a read-modify-write sequence: read the word, merge the lane(s), write it back. The block sits between the MEM stage and the DRAM, and it stalls the pipeline through busy while a read-modify-write is in flight.

---
 rtl/store_ctrl_ram.sv | 131 +++++++++++++
 1 files changed

// File: rtl/store_ctrl_ram.sv
// Store controller for a word-wide RAM with no byte enables: word stores write in one cycle,
// byte and halfword stores run read-modify-write. Optional trap build: define MISALIGN_TRAP_EN.
module store_ctrl_ram #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              TYPE_B,
    input  logic              TYPE_HB,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wd,
    input  logic [31:0]       ram_rd,
    output logic              busy,
    output logic              done,
    output logic              misalign
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-3:0] waddr_q;
    logic [1:0]        low_q;
    logic [31:0]       data_q;
    logic              byte_q;
    logic              done_q, done_d;
    logic              mis_q, mis_d;

    logic        is_byte, is_half, is_word, bad, sub_accept;
    logic [1:0]  low_in;
    logic [31:0] merged;

    assign is_byte = TYPE_B;
    assign is_half = ~TYPE_B & TYPE_HB;
    assign is_word = ~TYPE_B & ~TYPE_HB;

`ifdef MISALIGN_TRAP_EN
    assign bad = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
    assign bad = 1'b0;
`endif

    // Halfword lane is chosen by addr[1] alone; a stray addr[0] is dropped.
    assign low_in     = is_half ? {addr[1], 1'b0} : addr[1:0];
    assign sub_accept = (state_q == StIdle) & req & ~is_word & ~bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sub_accept) state_d = StRd;
            StRd:    state_d = StWr;
            StWr:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q <= '0;
            low_q   <= '0;
            data_q  <= '0;
            byte_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            if (sub_accept) begin
                waddr_q <= addr[ADDR_W-1:2];
                low_q   <= low_in;
                data_q  <= wd;
                byte_q  <= is_byte;
            end
            done_q <= done_d;
            mis_q  <= mis_d;
        end
    end

    always_comb begin
        merged = ram_rd;
        if (byte_q) begin
            merged[{low_q, 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged[{low_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wd   = '0;
        unique case (state_q)
            StIdle: begin
                ram_addr = addr[ADDR_W-1:2];
                if (req && is_word && !bad) begin
                    ram_we = 1'b1;
                    ram_wd = wd;
                end
            end
            StRd: ram_addr = waddr_q;
            StWr: begin
                ram_addr = waddr_q;
                ram_we   = 1'b1;
                ram_wd   = merged;
            end
            default: ram_we = 1'b0;
        endcase
        // Reset wins over any in-flight write, including the combinational word path.
        if (rst) begin
            ram_we   = 1'b0;
            ram_addr = '0;
            ram_wd   = '0;
        end
    end

    assign done_d   = ram_we;
    assign mis_d    = (state_q == StIdle) & req & bad & ~rst;
    assign busy     = (state_q != StIdle) & ~rst;
    assign done     = done_q;
    assign misalign = mis_q;

endmodule
